// File: rtl/mem_if_wr_arbiter_if.sv
// rtl/mem_if_wr_arbiter_if.sv - producer and writer stream bundle for the write-path arbiter
interface mem_if_wr_arbiter_if #(
   parameter int NUM_PORTS  = 4,
   parameter int DATA_WIDTH = 32
);
   logic [NUM_PORTS*DATA_WIDTH-1:0] s_axis_tdata;
   logic [NUM_PORTS-1:0]            s_axis_tlast;
   logic [NUM_PORTS-1:0]            s_axis_tvalid;
   logic [NUM_PORTS-1:0]            s_axis_tready;
   logic [DATA_WIDTH-1:0]           m_axis_tdata;
   logic                            m_axis_tlast;
   logic                            m_axis_tvalid;
   logic                            m_axis_tready;

   // Arbiter side: consumes producer streams, drives the writer stream.
   modport slave (
      input  s_axis_tdata, s_axis_tlast, s_axis_tvalid, m_axis_tready,
      output s_axis_tready, m_axis_tdata, m_axis_tlast, m_axis_tvalid
   );

   // Environment side: producers plus the writer's ready.
   modport master (
      output s_axis_tdata, s_axis_tlast, s_axis_tvalid, m_axis_tready,
      input  s_axis_tready, m_axis_tdata, m_axis_tlast, m_axis_tvalid
   );
endinterface

// File: rtl/mem_if_wr_arbiter.sv
// rtl/mem_if_wr_arbiter.sv - packet-level round-robin arbiter for the shared mem_if write path
module mem_if_wr_arbiter #(
   parameter int NUM_PORTS        = 4,
   parameter int DATA_WIDTH       = 32,
   parameter int CNT_WIDTH        = 16,
   parameter int AXI4L_DATA_WIDTH = 32
) (
   input  logic                            clk,
   input  logic                            reset,
   mem_if_wr_arbiter_if.slave              axis,
   input  logic [NUM_PORTS-1:0]            port_enable_in,
   output logic [NUM_PORTS-1:0]            grant_out,
   output logic [NUM_PORTS*CNT_WIDTH-1:0]  pkt_count_out,
   output logic                            idle_out,
   output logic [AXI4L_DATA_WIDTH-1:0]     state_vec_out
);
   localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

   typedef enum logic {
      STATE_ARB  = 1'b0,
      STATE_PASS = 1'b1
   } state_t;

   state_t                 state_q, state_d;
   logic [PW-1:0]          rr_ptr_q, rr_ptr_d;
   logic [PW-1:0]          gidx_q, gidx_d;
   logic [NUM_PORTS-1:0]   grant_q, grant_d;
   logic [CNT_WIDTH-1:0]   cnt_q [NUM_PORTS];
   logic                   idle_now_q;
   logic                   idle_q;

   logic [NUM_PORTS-1:0]   req;
   logic [PW-1:0]          cand;
   logic [PW-1:0]          sel_idx;
   logic                   sel_found;
   logic [DATA_WIDTH-1:0]  m_tdata;
   logic                   m_tlast;
   logic                   m_tvalid;
   logic [NUM_PORTS-1:0]   s_tready;
   logic                   last_xfer;

   // Port index arithmetic modulo NUM_PORTS; NUM_PORTS need not be a power of two.
   function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] base, input int off);
      logic [PW:0] s;
      s = {1'b0, base} + (PW+1)'(off);
      if (s >= (PW+1)'(NUM_PORTS)) begin
         s = s - (PW+1)'(NUM_PORTS);
      end
      return s[PW-1:0];
   endfunction

   assign req = axis.s_axis_tvalid & port_enable_in;

   // Round-robin pick: first requesting port at or above rr_ptr, wrapping.
   always_comb begin
      sel_idx   = '0;
      sel_found = 1'b0;
      cand      = '0;
      for (int k = 0; k < NUM_PORTS; k++) begin
         cand = wrap_add(rr_ptr_q, k);
         if (!sel_found && req[cand]) begin
            sel_idx   = cand;
            sel_found = 1'b1;
         end
      end
   end

   // Stream mux: only the granted producer is connected while a packet is in flight.
   always_comb begin
      m_tdata  = axis.s_axis_tdata[gidx_q*DATA_WIDTH +: DATA_WIDTH];
      m_tlast  = 1'b0;
      m_tvalid = 1'b0;
      s_tready = '0;
      if (state_q == STATE_PASS) begin
         m_tlast          = axis.s_axis_tlast[gidx_q];
         m_tvalid         = axis.s_axis_tvalid[gidx_q];
         s_tready[gidx_q] = axis.m_axis_tready;
      end
   end

   assign last_xfer          = m_tvalid & axis.m_axis_tready & m_tlast;
   assign axis.m_axis_tdata  = m_tdata;
   assign axis.m_axis_tlast  = m_tlast;
   assign axis.m_axis_tvalid = m_tvalid;
   assign axis.s_axis_tready = s_tready;

   // Next-state: grant on any request, release after the tlast beat is accepted.
   always_comb begin
      state_d  = state_q;
      rr_ptr_d = rr_ptr_q;
      gidx_d   = gidx_q;
      grant_d  = grant_q;
      case (state_q)
         STATE_ARB: begin
            if (sel_found) begin
               gidx_d           = sel_idx;
               grant_d          = '0;
               grant_d[sel_idx] = 1'b1;
               state_d          = STATE_PASS;
            end
         end
         STATE_PASS: begin
            if (last_xfer) begin
               rr_ptr_d = wrap_add(gidx_q, 1);
               grant_d  = '0;
               state_d  = STATE_ARB;
            end
         end
         default: state_d = STATE_ARB;
      endcase
   end

   // Arbitration state registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= STATE_ARB;
         rr_ptr_q <= '0;
         gidx_q   <= '0;
         grant_q  <= '0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         gidx_q   <= gidx_d;
         grant_q  <= grant_d;
      end
   end

   // Per-port completed-packet counters, wrapping naturally.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int p = 0; p < NUM_PORTS; p++) begin
            cnt_q[p] <= '0;
         end
      end else if (last_xfer) begin
         cnt_q[gidx_q] <= cnt_q[gidx_q] + CNT_WIDTH'(1);
      end
   end

   // Idle needs two consecutive quiet arbitration cycles to filter one-cycle bubbles.
   always_ff @(posedge clk) begin
      if (reset) begin
         idle_now_q <= 1'b1;
         idle_q     <= 1'b1;
      end else begin
         idle_now_q <= (state_q == STATE_ARB) && (req == '0);
         idle_q     <= (state_q == STATE_ARB) && (req == '0) && idle_now_q;
      end
   end

   // Flatten counters for the register bank.
   always_comb begin
      pkt_count_out = '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
         pkt_count_out[p*CNT_WIDTH +: CNT_WIDTH] = cnt_q[p];
      end
   end

   // Debug status word.
   always_comb begin
      state_vec_out        = '0;
      state_vec_out[7:0]   = {7'b0, state_q};
      state_vec_out[15:8]  = (grant_q == '0) ? 8'hFF : 8'(gidx_q);
      state_vec_out[23:16] = 8'(rr_ptr_q);
      state_vec_out[31:24] = {m_tvalid, axis.m_axis_tready, m_tlast, idle_q, 4'b0};
   end

   assign grant_out = grant_q;
   assign idle_out  = idle_q;
endmodule
